// File: rtl/piano_pkg.sv
// Shared definitions for the piano keyboard front end.
// Contents:
//   NOTE_C .. NOTE_C2 : note indices, matching the key and tone-generator order
//   NUM_NOTES         : number of tone generators / keys
//   CLK_HZ            : system clock frequency
//   state_e           : note-selection FSM state
package piano_pkg;

  localparam int NUM_NOTES = 8;
  localparam int CLK_HZ    = 25_000_000;

  localparam logic [2:0] NOTE_C  = 3'd0;
  localparam logic [2:0] NOTE_D  = 3'd1;
  localparam logic [2:0] NOTE_E  = 3'd2;
  localparam logic [2:0] NOTE_F  = 3'd3;
  localparam logic [2:0] NOTE_G  = 3'd4;
  localparam logic [2:0] NOTE_A  = 3'd5;
  localparam logic [2:0] NOTE_B  = 3'd6;
  localparam logic [2:0] NOTE_C2 = 3'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    SUSTAIN = 2'd2
  } state_e;

endpackage

// File: rtl/key_debounce.sv
// Single-key conditioning: polarity fix, 2-flop synchroniser, debouncer and
// press/release edge detector.
// Ports:
//   clk, rst_n    : system clock, asynchronous active-low reset
//   key_raw       : asynchronous button level
//   level         : debounced "pressed" level (1 = pressed)
//   press         : one-cycle pulse, registered together with level rising
//   release_pulse : one-cycle pulse, registered together with level falling
//                   (named this way because "release" is a reserved word)
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic level,
  output logic press,
  output logic release_pulse
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          rel_q, rel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pressed_raw;

  // After this XOR, 1 always means "pressed" and the released level is 0,
  // which is what every flop below resets to.
  assign pressed_raw = key_raw ^ KEY_ACTIVE_LOW;

  // The counter only runs while the synchronised level disagrees with the
  // debounced level; a single agreeing cycle restarts the qualification.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_TERM) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = level_d & ~level_q;
    rel_d   = ~level_d & level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync1_q <= pressed_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = rel_q;

endmodule

// File: rtl/piano_key_ctrl.sv
// Piano key controller: eight push buttons in, one-hot tone enable out.
// Each key is synchronised and debounced; a monophonic last-pressed-wins
// FSM picks the sounding note and holds it for a sustain time after the
// final key is released.
// Ports:
//   clk, rst_n  : 25 MHz system clock, asynchronous active-low reset
//   key_raw     : raw button levels, index 0 = C .. 7 = C2
//   note_en     : one-hot (or zero) tone-generator enable
//   note_idx    : index of the sounding note, 0 when idle
//   playing     : high whenever note_en is nonzero
//   note_change : one-cycle pulse when note_en shows a new nonzero value
//   dbg_state   : current FSM state, for observation only
module piano_key_ctrl
  import piano_pkg::*;
#(
  parameter int NUM_KEYS        = NUM_NOTES,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SUSTAIN_CYCLES  = 2500000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] note_en,
  output logic [2:0]          note_idx,
  output logic                playing,
  output logic                note_change,
  output state_e              dbg_state
);

  // A single-cycle sustain would give a zero-width counter; keep one bit.
  localparam int            SW       = (SUSTAIN_CYCLES > 1) ? $clog2(SUSTAIN_CYCLES) : 1;
  localparam logic [SW-1:0] SUS_TERM = SW'(SUSTAIN_CYCLES - 1);

  logic [NUM_KEYS-1:0] level_v, press_v, release_v;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
    ) u_debounce (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_raw      (key_raw[k]),
      .level        (level_v[k]),
      .press        (press_v[k]),
      .release_pulse(release_v[k])
    );
  end

  function automatic logic [2:0] lowest_idx(input logic [NUM_KEYS-1:0] v);
    lowest_idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = 3'(i);
    end
  endfunction

  state_e              state_q, state_d;
  logic [2:0]          cur_q, cur_d;
  logic [SW-1:0]       sus_cnt_q, sus_cnt_d;
  logic [NUM_KEYS-1:0] note_en_q, note_en_d;
  logic                playing_q, playing_d;
  logic                note_change_q, note_change_d;

  // Presses are checked before releases in every state, so a press and a
  // release landing on the same cycle always resolve to the press.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    sus_cnt_d = sus_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|press_v) begin
          state_d = PLAY;
          cur_d   = lowest_idx(press_v);
        end
      end
      PLAY: begin
        if (|press_v) begin
          cur_d = lowest_idx(press_v);
        end else if (release_v[cur_q]) begin
          if (|level_v) begin
            cur_d = lowest_idx(level_v);
          end else begin
            state_d   = SUSTAIN;
            sus_cnt_d = '0;
          end
        end
      end
      SUSTAIN: begin
        if (|press_v) begin
          state_d   = PLAY;
          cur_d     = lowest_idx(press_v);
          sus_cnt_d = '0;
        end else if (sus_cnt_q == SUS_TERM) begin
          state_d   = IDLE;
          cur_d     = '0;
          sus_cnt_d = '0;
        end else begin
          sus_cnt_d = sus_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        cur_d     = '0;
        sus_cnt_d = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    note_en_d     = (state_d == IDLE) ? '0 : (NUM_KEYS'(1) << cur_d);
    playing_d     = (state_d != IDLE);
    // Re-pressing the sounding key leaves note_en unchanged, so no pulse.
    note_change_d = (|note_en_d) && (note_en_d != note_en_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cur_q         <= '0;
      sus_cnt_q     <= '0;
      note_en_q     <= '0;
      playing_q     <= 1'b0;
      note_change_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      sus_cnt_q     <= sus_cnt_d;
      note_en_q     <= note_en_d;
      playing_q     <= playing_d;
      note_change_q <= note_change_d;
    end
  end

  assign note_en     = note_en_q;
  assign note_idx    = cur_q;
  assign playing     = playing_q;
  assign note_change = note_change_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_piano_key_ctrl.sv
// Bench for piano_key_ctrl with short debounce/sustain times and
// active-high keys. Directed scenarios with literal expectations, then
// randomized key activity checked every cycle against a behavioural model.
module tb_piano_key_ctrl;
  import piano_pkg::*;

  localparam int DC = 4;
  localparam int SC = 8;
  localparam int W  = 15;

  logic       clk;
  logic       rst_n;
  logic [7:0] key_raw;
  logic [7:0] note_en;
  logic [2:0] note_idx;
  logic       playing;
  logic       note_change;
  state_e     dbg_state;

  int checks = 0;
  int errors = 0;

  // Expected {note_change, playing, note_idx, note_en, state}, one per edge.
  logic [W-1:0] exp_q[$];

  piano_key_ctrl #(
    .NUM_KEYS       (8),
    .DEBOUNCE_CYCLES(DC),
    .SUSTAIN_CYCLES (SC),
    .KEY_ACTIVE_LOW (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_raw    (key_raw),
    .note_en    (note_en),
    .note_idx   (note_idx),
    .playing    (playing),
    .note_change(note_change),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- behavioural model ----------------
  logic [7:0] hist[$];     // raw key samples, one per rising edge
  logic [7:0] m_deb;       // accepted key levels
  logic [7:0] m_press;     // keys accepted as pressed on the previous edge
  logic [7:0] m_rel;       // keys accepted as released on the previous edge
  logic [7:0] m_en;
  logic       m_chg;
  bit         m_active;
  int         m_note;
  int         m_sus;       // sustain cycles remaining, 0 = not sustaining

  function automatic int lowest_set(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [W-1:0] model_word();
    logic [1:0] s;
    s = !m_active ? 2'(IDLE) : ((m_sus > 0) ? 2'(SUSTAIN) : 2'(PLAY));
    return {m_chg, m_active, (m_active ? 3'(m_note) : 3'd0), m_en, s};
  endfunction

  task automatic model_reset();
    hist.delete();
    hist.push_back(8'h00);
    hist.push_back(8'h00);
    m_deb = 0; m_press = 0; m_rel = 0; m_en = 0; m_chg = 0;
    m_active = 0; m_note = 0; m_sus = 0;
  endtask

  task automatic model_step();
    logic [7:0] prev_en;
    logic [7:0] s;
    bit         all_diff;
    // Note choice reacts to keys accepted on the previous edge.
    prev_en = m_en;
    if (m_press != 0) begin
      m_note = lowest_set(m_press); m_active = 1; m_sus = 0;
    end else if (m_active && m_sus == 0 && m_rel[m_note]) begin
      if (m_deb != 0) m_note = lowest_set(m_deb);
      else m_sus = SC;
    end else if (m_sus > 0) begin
      m_sus--;
      if (m_sus == 0) m_active = 0;
    end
    m_en  = m_active ? (8'(1) << m_note) : 8'h00;
    m_chg = (m_en != 0) && (m_en != prev_en);
    // A key level is accepted once DC consecutive samples, seen two
    // edges late through the synchroniser, all disagree with it.
    hist.push_back(key_raw);
    while (hist.size() > DC + 4) void'(hist.pop_front());
    m_press = 0; m_rel = 0;
    for (int k = 0; k < 8; k++) begin
      all_diff = 1;
      for (int j = 0; j < DC; j++) begin
        s = hist[hist.size() - 3 - j];
        if (s[k] == m_deb[k]) all_diff = 0;
      end
      if (all_diff) begin
        m_deb[k] = ~m_deb[k];
        if (m_deb[k]) m_press[k] = 1'b1;
        else m_rel[k] = 1'b1;
      end
    end
  endtask

  initial begin
    model_reset();
    exp_q.push_back(model_word());
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
      exp_q.push_back(model_word());
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : compare_proc
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cycle: got no model expectation at %0t", $time);
      end else begin
        while (exp_q.size() > 0) e = exp_q.pop_front();
        chk("cycle", 16'({note_change, playing, note_idx, note_en, 2'(dbg_state)}), 16'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_keys(input logic [7:0] v);
    @(negedge clk);
    key_raw = v;
  endtask

  task automatic check_outputs(input string name, input logic [7:0] en,
                               input logic [2:0] idx, input logic chg);
    chk({name, "_en"},  16'(note_en), 16'(en));
    chk({name, "_idx"}, 16'(note_idx), 16'(idx));
    chk({name, "_play"}, 16'(playing), 16'(en != 0));
    chk({name, "_chg"}, 16'(note_change), 16'(chg));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] v;
    rst_n   = 1'b1;
    key_raw = 8'h00;
    #1 rst_n = 1'b0;
    wait_neg(3);
    check_outputs("reset", 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
    wait_neg(3);

    // Key 0: note appears exactly DC+3 edges after the first sampling edge.
    set_keys(8'h01);
    wait_neg(6);
    check_outputs("k0_before", 8'h00, 3'd0, 1'b0);
    wait_neg(1);
    check_outputs("k0_on", 8'h01, 3'd0, 1'b1);
    chk("model_k0_on", 16'(m_en), 16'h0001);
    wait_neg(1);
    check_outputs("k0_hold", 8'h01, 3'd0, 1'b0);
    // Release: held through the sustain, silent at edge DC+3+SC.
    set_keys(8'h00);
    wait_neg(14);
    check_outputs("k0_sustain", 8'h01, 3'd0, 1'b0);
    chk("model_k0_sus", 16'(m_sus), 16'd1);
    wait_neg(1);
    check_outputs("k0_off", 8'h00, 3'd0, 1'b0);

    // Glitch on key 2 lasting three samples.
    set_keys(8'h04);
    wait_neg(2);
    set_keys(8'h00);
    for (int i = 0; i < 12; i++) begin
      wait_neg(1);
      check_outputs("glitch", 8'h00, 3'd0, 1'b0);
    end

    // Hold key 1, press key 5, release key 5.
    set_keys(8'h02);
    wait_neg(10);
    check_outputs("k1", 8'h02, 3'd1, 1'b0);
    set_keys(8'h22);
    wait_neg(6);
    check_outputs("k5_before", 8'h02, 3'd1, 1'b0);
    wait_neg(1);
    check_outputs("k5_on", 8'h20, 3'd5, 1'b1);
    wait_neg(3);
    set_keys(8'h02);
    wait_neg(6);
    check_outputs("k5_rel_before", 8'h20, 3'd5, 1'b0);
    wait_neg(1);
    check_outputs("back_to_k1", 8'h02, 3'd1, 1'b1);
    set_keys(8'h00);
    wait_neg(20);

    // Keys 3 and 6 on the same cycle: lowest wins.
    set_keys(8'h48);
    wait_neg(7);
    check_outputs("k3k6", 8'h08, 3'd3, 1'b1);
    set_keys(8'h00);
    wait_neg(20);

    // Release key 4, press key 7 four cycles later, inside the sustain.
    set_keys(8'h10);
    wait_neg(10);
    check_outputs("k4", 8'h10, 3'd4, 1'b0);
    set_keys(8'h00);
    wait_neg(3);
    set_keys(8'h80);
    for (int i = 0; i < 6; i++) begin
      wait_neg(1);
      check_outputs("k4_sustain", 8'h10, 3'd4, 1'b0);
    end
    wait_neg(1);
    check_outputs("k7_on", 8'h80, 3'd7, 1'b1);
    set_keys(8'h00);
    wait_neg(20);

    // Reset while key 6 sounds; key still held afterwards.
    set_keys(8'h40);
    wait_neg(10);
    check_outputs("k6", 8'h40, 3'd6, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_outputs("async_reset", 8'h00, 3'd0, 1'b0);
    wait_neg(2);
    rst_n = 1'b1;
    wait_neg(6);
    check_outputs("k6_relearn_before", 8'h00, 3'd0, 1'b0);
    wait_neg(1);
    check_outputs("k6_relearn", 8'h40, 3'd6, 1'b1);
    set_keys(8'h00);
    wait_neg(20);

    // Randomized activity, checked every cycle by the compare process.
    for (int it = 0; it < 300; it++) begin
      v = key_raw;
      case ($urandom_range(0, 4))
        0: v = v ^ (8'(1) << $urandom_range(0, 7));
        1: v = 8'($urandom_range(0, 255));
        2: v = 8'h00;
        3: v = v ^ (8'(1) << $urandom_range(0, 7)) ^ (8'(1) << $urandom_range(0, 7));
        default: v = 8'(1) << $urandom_range(0, 7);
      endcase
      set_keys(v);
      if ($urandom_range(0, 3) == 0) wait_neg($urandom_range(10, 30));
      else wait_neg($urandom_range(0, 8));
      if (it == 150) begin
        #2 rst_n = 1'b0;
        wait_neg(2);
        rst_n = 1'b1;
      end
    end
    set_keys(8'h00);
    wait_neg(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/piano_key_ctrl.md
Name: piano_key_ctrl

Overview:
- Upstream stage of the eight tone generators (C, D, E, F, G, A, B, C2).
- Turns eight raw push-button inputs into the one-hot tone-enable vector that gates those generators.
- Per-key synchronisation and debounce, then monophonic last-pressed-wins note selection, with a short sustain after release.
- Runs on the 25 MHz system clock.

Parameters:
- NUM_KEYS, 8, number of keys; index 0 = C through 7 = C2.
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a key level change (10 ms). Must be at least 2.
- SUSTAIN_CYCLES, 2500000, cycles the last note keeps sounding after all keys are released (100 ms). Must be at least 1.
- KEY_ACTIVE_LOW, 1, 1 = a pressed button drives 0 on key_raw.

Ports:
- clk, input, 1, system clock (25 MHz).
- rst_n, input, 1, asynchronous active-low reset.
- key_raw, input, NUM_KEYS, asynchronous button levels.
- note_en, output, NUM_KEYS, one-hot (or zero) enable to the tone generators; bit i drives the enable of note i.
- note_idx, output, 3, index of the sounding note; 0 when idle.
- playing, output, 1, high whenever note_en is nonzero.
- note_change, output, 1, one-cycle pulse when note_en takes a new nonzero value.

Behaviour:
- Reset (async, active-low): all outputs 0, FSM IDLE, every sync/debounce flop and counter cleared.
  - Sync flops reset to the "released" level.
  - Release of reset is synchronous to clk.
- Key path, per key:
  - Polarity fix: pressed = key_raw XOR KEY_ACTIVE_LOW.
  - 2-flop synchroniser.
  - Debouncer:
    - A counter increments while the synchronised level differs from the debounced state.
    - The counter clears to 0 on any cycle the two agree.
    - On reaching DEBOUNCE_CYCLES-1 while still differing, the debounced state toggles and the counter clears.
    - A glitch shorter than DEBOUNCE_CYCLES never toggles the debounced state.
  - Edge detector: a press pulse on a debounced 0 to 1 transition.
- Latency: from the first clk edge that samples a new stable key level to the note_en update is exactly DEBOUNCE_CYCLES+3 cycles (2 sync, DEBOUNCE_CYCLES count, 1 output register).
- FSM states: IDLE, PLAY, SUSTAIN.
  - IDLE:
    - Any press pulse -> PLAY with the lowest pressed-pulse index.
  - PLAY:
    - A press pulse on another key -> switch to it.
    - Simultaneous pulses -> lowest index wins.
    - If the current key releases and other keys are still held -> switch to the lowest held index, stay in PLAY.
    - If the current key releases and no keys are held -> SUSTAIN; note_en unchanged; sustain counter loads 0.
    - A release and a press in the same cycle -> the press wins.
  - SUSTAIN:
    - The counter increments each cycle.
    - At SUSTAIN_CYCLES-1 -> IDLE and note_en goes to 0 on the next cycle.
    - Any press pulse -> PLAY with the new key, counter cleared.
    - Pressing the same key again restarts PLAY with no note_change pulse.
- Outputs:
  - All registered.
  - note_en is zero in IDLE and exactly one-hot otherwise.
  - note_idx is the encoded form of note_en.
  - playing = |note_en.
  - note_change pulses in the same cycle note_en first shows a different nonzero value, including IDLE to PLAY.
- Counter widths: $clog2 of the respective parameter; no wrap-around occurs because counters clear at terminal count.
- Reset asserted mid-note: note_en drops to 0 asynchronously; no sustain.

Decomposition:
- Shared package piano_pkg:
  - Note index constants NOTE_C=0 through NOTE_C2=7.
  - NUM_NOTES=8.
  - State enum {IDLE, PLAY, SUSTAIN}.
  - CLK_HZ=25_000_000.
- One sub-module, key_debounce: a single-key synchroniser, debouncer and edge detector with parameters DEBOUNCE_CYCLES and KEY_ACTIVE_LOW. It has outputs level, press, release and is instantiated NUM_KEYS times in a generate loop.

Test Plan (DEBOUNCE_CYCLES=4, SUSTAIN_CYCLES=8, KEY_ACTIVE_LOW=0):
- Press key 0 held steady -> note_en=8'h01, note_idx=0, note_change pulse exactly 7 cycles after the first sampling edge; release -> note_en held 8 more cycles, then 8'h00.
- Key 2 pulsed high for 3 cycles (glitch) -> note_en stays 8'h00, no note_change.
- Hold key 1, then press key 5 -> note_en 8'h02 then 8'h20; release key 5 -> note_en 8'h02 with a note_change pulse.
- Keys 3 and 6 pressed on the same cycle -> note_en=8'h08, note_idx=3.
- Release key 4, press key 7 four cycles later, during SUSTAIN -> note_en goes straight from 8'h10 to 8'h80 with no zero gap.
- rst_n pulled low while note_en=8'h40 -> all outputs 0 immediately; key still held after reset release -> note_en=8'h40 after DEBOUNCE_CYCLES+3 cycles.
